// File: rtl/vproc_mem_responder.sv
// Word-wide RAM target for the VProc memory-mapped initiator bus, with programmable wait states.
// Acks are single-cycle registered pulses, so several responders can be OR-ed onto one initiator.
module vproc_mem_responder #(
    parameter int          ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter int          BURST_WAIT  = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic [3:0]  BE,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] DataOut,
    input  logic [11:0] Burst,
    input  logic        BurstFirst,
    input  logic        BurstLast,
    output logic [31:0] DataIn,
    output logic        WRAck,
    output logic        RDAck,
    output logic        ProtErr,
    output logic [15:0] WrBeats,
    output logic [15:0] RdBeats
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    localparam logic [15:0] WS_L = 16'(WAIT_STATES);
    localparam logic [15:0] BW_L = 16'(BURST_WAIT);

    state_e               state_q, state_d;
    logic [15:0]          wait_q, wait_d;
    logic [11:0]          beat_q, beat_d;
    logic                 err_q, err_d;
    logic                 wrack_q, rdack_q;
    logic [31:0]          din_q;
    logic [15:0]          wrb_q, rdb_q;
    logic [31:0]          mem_q [2**ADDR_BITS];

    logic [ADDR_BITS-1:0] idx;
    logic                 hit, req, commit, wr_en, rd_en;
    logic [15:0]          load_w;

    assign idx    = Addr[ADDR_BITS-1:0];
    assign hit    = (Addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign req    = (WE | RD) & hit;
    assign load_w = (beat_q != 12'd0) ? BW_L : WS_L;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = (load_w != 16'd0) ? WAIT : ACK;
            WAIT:    if (wait_q <= 16'd1) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything commits on the edge entering ACK; WE wins when both requests are high.
    always_comb begin
        wait_d = wait_q;
        beat_d = beat_q;
        err_d  = err_q;
        commit = (state_d == ACK) && (state_q != ACK) && !Reset;
        wr_en  = commit & WE;
        rd_en  = commit & ~WE & RD;
        case (state_q)
            IDLE: if (req) begin
                wait_d = load_w;
                if (BurstFirst) beat_d = Burst;
                if (BurstFirst && Burst == 12'd0) err_d = 1'b1;
                if (WE && RD) err_d = 1'b1;
            end
            WAIT: wait_d = wait_q - 16'd1;
            ACK: begin
                // The acked beat is still presented here, so BurstLast is checked against it.
                if (beat_q != 12'd0) beat_d = beat_q - 12'd1;
                if (BurstLast ? (beat_q != 12'd1) : (beat_q == 12'd1)) err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wait_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            wrack_q <= 1'b0;
            rdack_q <= 1'b0;
            din_q   <= '0;
            wrb_q   <= '0;
            rdb_q   <= '0;
        end else begin
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            wrack_q <= wr_en;
            rdack_q <= rd_en;
            if (wr_en) wrb_q <= wrb_q + 16'd1;
            if (rd_en) begin
                rdb_q <= rdb_q + 16'd1;
                din_q <= mem_q[idx];
            end
        end
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++)
            if (wr_en && BE[i]) mem_q[idx][8*i +: 8] <= DataOut[8*i +: 8];
    end

    assign DataIn  = din_q;
    assign WRAck   = wrack_q;
    assign RDAck   = rdack_q;
    assign ProtErr = err_q;
    assign WrBeats = wrb_q;
    assign RdBeats = rdb_q;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Three responders with different windows and wait settings share one initiator bus;
// random and directed beats are checked against a transaction-level memory model.
module tb_vproc_mem_responder;

    localparam int         WS   [3] = '{0, 3, 5};
    localparam int         BW   [3] = '{1, 0, 2};
    localparam bit [31:0]  BASE [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000};

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Addr, DataOut;
    logic [3:0]  BE;
    logic        WE, RD, BurstFirst, BurstLast;
    logic [11:0] Burst;
    logic [31:0] din   [3];
    logic        wrack [3];
    logic        rdack [3];
    logic        perr  [3];
    logic [15:0] wrb   [3];
    logic [15:0] rdb   [3];

    always #5 Clk = ~Clk;

    vproc_mem_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0), .BURST_WAIT(1)) u_a (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .BE(BE), .WE(WE), .RD(RD), .DataOut(DataOut),
        .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast), .DataIn(din[0]),
        .WRAck(wrack[0]), .RDAck(rdack[0]), .ProtErr(perr[0]), .WrBeats(wrb[0]), .RdBeats(rdb[0]));
    vproc_mem_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3), .BURST_WAIT(0)) u_b (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .BE(BE), .WE(WE), .RD(RD), .DataOut(DataOut),
        .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast), .DataIn(din[1]),
        .WRAck(wrack[1]), .RDAck(rdack[1]), .ProtErr(perr[1]), .WrBeats(wrb[1]), .RdBeats(rdb[1]));
    vproc_mem_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(5), .BURST_WAIT(2)) u_c (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .BE(BE), .WE(WE), .RD(RD), .DataOut(DataOut),
        .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast), .DataIn(din[2]),
        .WRAck(wrack[2]), .RDAck(rdack[2]), .ProtErr(perr[2]), .WrBeats(wrb[2]), .RdBeats(rdb[2]));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ack = 0;
    int prev_ack = 0;

    // model state
    bit [31:0] m_mem [int];
    int        m_beat [3];
    bit        m_err  [3];
    bit [15:0] m_wr   [3];
    bit [15:0] m_rd   [3];
    bit [31:0] m_din  [3];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle_bus();
        WE = 0; RD = 0; BurstFirst = 0; BurstLast = 0; Burst = '0;
        BE = 4'hF; DataOut = '0; Addr = 32'hFFFF_0000;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_beat[i] = 0; m_err[i] = 0; m_wr[i] = 0; m_rd[i] = 0; m_din[i] = 0;
        end
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < 3; i++) begin
            chk("rst_din", din[i], 32'h0);
            chk("rst_acks", {30'h0, wrack[i], rdack[i]}, 32'h0);
            chk("rst_perr", perr[i], 32'h0);
            chk("rst_beats", {wrb[i], rdb[i]}, 32'h0);
        end
    endtask

    // One beat: update the model from the bus rules, present it, wait for the ack, check everything.
    task automatic beat(input int i, input bit we, input bit rd, input bit [11:0] idx, input bit [3:0] be,
                        input bit [31:0] wd, input bit bf, input bit [11:0] blen, input bit bl);
        int w, n, key;
        bit got, other;
        bit [31:0] nw;
        w = (m_beat[i] != 0) ? BW[i] : WS[i];
        if (bf) m_beat[i] = (blen == 0) ? 0 : int'(blen);
        if (bf && blen == 0) m_err[i] = 1;
        if (we && rd) m_err[i] = 1;
        if (bl ? (m_beat[i] != 1) : (m_beat[i] == 1)) m_err[i] = 1;
        if (m_beat[i] != 0) m_beat[i]--;
        key = i * 4096 + int'(idx);
        if (we) begin
            nw = m_mem.exists(key) ? m_mem[key] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
            m_mem[key] = nw;
            m_wr[i]++;
        end else begin
            m_din[i] = m_mem.exists(key) ? m_mem[key] : 32'h0;
            m_rd[i]++;
        end
        Addr = BASE[i] + {20'h0, idx}; WE = we; RD = rd; BE = be; DataOut = wd;
        BurstFirst = bf; Burst = blen; BurstLast = bl;
        got = 0; n = 0;
        while (!got && n < 40) begin
            @(posedge Clk); #1;
            n++;
            got = we ? wrack[i] : rdack[i];
        end
        chk("ack_latency", n, w + 1);
        other = we ? rdack[i] : wrack[i];
        for (int j = 0; j < 3; j++) if (j != i) other |= wrack[j] | rdack[j];
        chk("stray_ack", other, 0);
        if (!we) chk("rdata", din[i], m_din[i]);
        prev_ack = last_ack; last_ack = cyc;
        @(posedge Clk); #1;
        chk("ack_width", {wrack[i], rdack[i]}, 0);
        chk("prot_err", perr[i], m_err[i]);
        chk("wr_beats", wrb[i], m_wr[i]);
        chk("rd_beats", rdb[i], m_rd[i]);
    endtask

    task automatic single(input int i, input bit we, input bit [11:0] idx, input bit [3:0] be, input bit [31:0] wd);
        beat(i, we, !we, idx, be, wd, 0, 12'h0, 0);
    endtask

    task automatic burst(input int i, input bit we, input bit [11:0] idx0, input int len);
        for (int k = 0; k < len; k++) begin
            beat(i, we, !we, idx0 + 12'(k), 4'hF, $urandom, k == 0, (k == 0) ? 12'(len) : 12'h0, k == len - 1);
            if (k > 0) chk("beat_gap", last_ack - prev_ack, BW[i] + 2);
        end
    endtask

    initial begin
        bit [31:0] saved;
        bit        seen;
        int        i, op;
        bit [11:0] idx;

        Reset = 1'b1;
        idle_bus();
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk) Reset = 1'b0;
        #1 chk_reset_state();

        // zero-wait write then read
        single(0, 1, 12'h010, 4'hF, 32'hDEAD_BEEF);
        single(0, 0, 12'h010, 4'hF, 32'h0);
        chk("deadbeef", din[0], 32'hDEAD_BEEF);

        // three wait states on a single read
        single(1, 1, 12'h005, 4'hF, 32'hCAFE_F00D);
        single(1, 0, 12'h005, 4'hF, 32'h0);

        // byte-lane merge
        single(0, 1, 12'h030, 4'hF, 32'h1122_3344);
        single(0, 1, 12'h030, 4'b0101, 32'hAABB_CCDD);
        single(0, 0, 12'h030, 4'hF, 32'h0);
        chk("be_merge", din[0], 32'h11BB_33DD);

        // 4-beat burst write then read back
        burst(0, 1, 12'h020, 4);
        burst(0, 0, 12'h020, 4);
        burst(2, 1, 12'h020, 3);
        burst(2, 0, 12'h020, 3);

        // random traffic on pre-initialised words
        for (int k = 0; k < 16; k++) begin
            single(0, 1, 12'h100 + 12'(k), 4'hF, $urandom);
            single(1, 1, 12'h100 + 12'(k), 4'hF, $urandom);
            single(2, 1, 12'h100 + 12'(k), 4'hF, $urandom);
        end
        for (int k = 0; k < 40; k++) begin
            i  = $urandom_range(0, 2);
            op = $urandom_range(0, 3);
            case (op)
                0: single(i, 1, 12'h100 + 12'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
                1: single(i, 0, 12'h100 + 12'($urandom_range(0, 15)), 4'hF, 32'h0);
                2: burst(i, 1, 12'h100 + 12'($urandom_range(0, 12)), $urandom_range(1, 4));
                default: burst(i, 0, 12'h100 + 12'($urandom_range(0, 12)), $urandom_range(1, 4));
            endcase
        end

        // early BurstLast in a 4-beat burst, error must stay set
        beat(1, 1, 0, 12'h060, 4'hF, $urandom, 1, 12'd4, 0);
        beat(1, 1, 0, 12'h061, 4'hF, $urandom, 0, 12'd0, 1);
        beat(1, 1, 0, 12'h062, 4'hF, $urandom, 0, 12'd0, 0);
        beat(1, 1, 0, 12'h063, 4'hF, $urandom, 0, 12'd0, 1);
        single(1, 0, 12'h061, 4'hF, 32'h0);
        chk("perr_sticky", perr[1], 32'h1);

        // WE and RD together: performed as a write, flags an error
        beat(2, 1, 1, 12'h070, 4'hF, 32'h0BAD_F00D, 0, 12'h0, 0);
        single(2, 0, 12'h070, 4'hF, 32'h0);
        chk("we_rd_write", din[2], 32'h0BAD_F00D);
        // BurstFirst with a zero count behaves as a single access
        beat(0, 1, 0, 12'h080, 4'hF, 32'h1234_5678, 1, 12'd0, 0);
        single(0, 0, 12'h080, 4'hF, 32'h0);

        // access outside every window
        saved = din[0];
        idle_bus();
        Addr = 32'h8000_0010; RD = 1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk); #1;
            for (int j = 0; j < 3; j++) seen |= wrack[j] | rdack[j];
        end
        chk("miss_ack", seen, 0);
        chk("miss_din", din[0], saved);
        idle_bus();
        @(posedge Clk); #1;

        // reset while a write is waiting
        single(2, 1, 12'h040, 4'hF, 32'h5A5A_0001);
        Addr = BASE[2] + 32'h40; WE = 1; DataOut = 32'hBAD0_BAD0; BE = 4'hF;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk); #1;
            seen |= wrack[2] | rdack[2];
        end
        chk("rst_no_ack", seen, 0);
        idle_bus();
        model_reset();
        @(negedge Clk) Reset = 1'b0;
        #1 chk_reset_state();
        single(2, 0, 12'h040, 4'hF, 32'h0);
        chk("rst_discard", din[2], 32'h5A5A_0001);
        single(2, 1, 12'h041, 4'hF, 32'h7777_8888);
        single(2, 0, 12'h041, 4'hF, 32'h0);

        idle_bus();
        repeat (2) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
